// File: rtl/toaplan2_snd_mixer_if.sv
// Channel/strobe/output bundle of the N-channel sound mixer.
// The master side (game top-level or bench) drives samples and strobes; the mixer is the slave.
interface toaplan2_snd_mixer_if #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int OUT_W = 16
);
    logic                    CEN;
    logic [NCH*W-1:0]        CH_DIN;
    logic [NCH-1:0]          CH_EN;
    logic [2*NCH-1:0]        CH_LEVEL;
    logic [2*NCH-1:0]        CH_PAN;
    logic                    MUTE;
    logic signed [OUT_W-1:0] LEFT;
    logic signed [OUT_W-1:0] RIGHT;
    logic                    SAMPLE;
    logic                    PEAK;
    logic                    BUSY;
    logic                    OVERRUN;

    modport master (
        output CEN, CH_DIN, CH_EN, CH_LEVEL, CH_PAN, MUTE,
        input  LEFT, RIGHT, SAMPLE, PEAK, BUSY, OVERRUN
    );

    modport slave (
        input  CEN, CH_DIN, CH_EN, CH_LEVEL, CH_PAN, MUTE,
        output LEFT, RIGHT, SAMPLE, PEAK, BUSY, OVERRUN
    );
endinterface

// File: rtl/toaplan2_snd_mixer.sv
// Serial N-channel stereo mixer: snapshot on CEN, accumulate one channel per cycle,
// then saturate to OUT_W and emit a stereo pair with a SAMPLE pulse and a PEAK flag.
module toaplan2_snd_mixer #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int OUT_W = 16,
    parameter int ACC_W = 20
) (
    input  logic                  CLK,
    input  logic                  RESET,
    toaplan2_snd_mixer_if.slave   bus
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    generate
        if (NCH < 1 || NCH > 16) begin : g_nch_chk
            $error("toaplan2_snd_mixer: NCH must be in 1..16");
        end
        if (ACC_W < W + 2 + $clog2(NCH)) begin : g_acc_chk
            $error("toaplan2_snd_mixer: ACC_W must be >= W+2+clog2(NCH)");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  accl_q, accl_d, accr_q, accr_d;
    logic signed [OUT_W-1:0]  left_q, left_d, right_q, right_d;
    logic                     sample_q, sample_d;
    logic                     peak_q, peak_d;
    logic                     overrun_q, overrun_d;
    logic                     snap;
    logic signed [ACC_W-1:0]  term;
    logic [OUT_W:0]           sat_l, sat_r;

    logic signed [W-1:0]      din_q [NCH];
    logic [NCH-1:0]           en_q;
    logic [1:0]               lvl_q [NCH];
    logic [1:0]               pan_q [NCH];

    // Sign-extend first so the x2/x4 shifts can never wrap the accumulator.
    function automatic logic signed [ACC_W-1:0] gain(input logic signed [W-1:0] x,
                                                     input logic [1:0] code);
        logic signed [ACC_W-1:0] ext;
        ext = ACC_W'(x);
        case (code)
            2'd0:    gain = ext >>> 1;
            2'd1:    gain = ext;
            2'd2:    gain = ext <<< 1;
            default: gain = ext <<< 2;
        endcase
    endfunction

    // Returns {clip, value}.
    function automatic logic [OUT_W:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [CW-1:0] ax, mx, mn;
        ax = CW'(a);
        mx = CW'($signed({1'b0, {(OUT_W-1){1'b1}}}));
        mn = CW'($signed({1'b1, {(OUT_W-1){1'b0}}}));
        if (ax > mx)      sat = {1'b1, mx[OUT_W-1:0]};
        else if (ax < mn) sat = {1'b1, mn[OUT_W-1:0]};
        else              sat = {1'b0, ax[OUT_W-1:0]};
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        accl_d    = accl_q;
        accr_d    = accr_q;
        left_d    = left_q;
        right_d   = right_q;
        sample_d  = 1'b0;
        peak_d    = peak_q;
        overrun_d = overrun_q;
        snap      = 1'b0;
        term      = '0;
        sat_l     = '0;
        sat_r     = '0;
        case (state_q)
            IDLE: begin
                if (bus.CEN) begin
                    snap    = 1'b1;
                    accl_d  = '0;
                    accr_d  = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                overrun_d = overrun_q | bus.CEN;
                term = en_q[idx_q] ? gain(din_q[idx_q], lvl_q[idx_q]) : '0;
                if (pan_q[idx_q][1]) accl_d = accl_q + term;
                if (pan_q[idx_q][0]) accr_d = accr_q + term;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCH - 1)) state_d = OUTPUT;
            end
            OUTPUT: begin
                overrun_d = overrun_q | bus.CEN;
                sat_l     = sat(accl_q);
                sat_r     = sat(accr_q);
                left_d    = bus.MUTE ? '0 : $signed(sat_l[OUT_W-1:0]);
                right_d   = bus.MUTE ? '0 : $signed(sat_r[OUT_W-1:0]);
                peak_d    = sat_l[OUT_W] | sat_r[OUT_W];
                sample_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            accl_q    <= '0;
            accr_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            sample_q  <= 1'b0;
            peak_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            accl_q    <= accl_d;
            accr_q    <= accr_d;
            left_q    <= left_d;
            right_q   <= right_d;
            sample_q  <= sample_d;
            peak_q    <= peak_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot registers hold only data; their contents are ignored outside ACCUM.
    always_ff @(posedge CLK) begin
        if (snap) begin
            en_q <= bus.CH_EN;
            for (int i = 0; i < NCH; i++) begin
                din_q[i] <= bus.CH_DIN[i*W +: W];
                lvl_q[i] <= bus.CH_LEVEL[2*i +: 2];
                pan_q[i] <= bus.CH_PAN[2*i +: 2];
            end
        end
    end

    assign bus.LEFT    = left_q;
    assign bus.RIGHT   = right_q;
    assign bus.SAMPLE  = sample_q;
    assign bus.PEAK    = peak_q;
    assign bus.BUSY    = (state_q != IDLE);
    assign bus.OVERRUN = overrun_q;
endmodule

// File: doc/toaplan2_snd_mixer.md
Name: toaplan2_snd_mixer

Overview:
- Parametrised N-channel sound mixer that generalises the per-game fixed FX/FM level mixing into one reusable block.
- Sits between the per-chip sound cores (YM2151, OKI, future QSound/YMZ) and the game top-level snd_left/snd_right/sample outputs.
- On each sample strobe it snapshots all channels and applies a 2-bit gain and a pan per channel. It accumulates serially, one channel per cycle, then saturates and outputs a stereo pair with a sample pulse and a clip flag.

Parameters:
- NCH, 4: number of input channels, 1..16.
- W, 16: signed width of each channel input.
- OUT_W, 16: signed width of LEFT/RIGHT outputs.
- ACC_W, 20: signed accumulator width. Must be >= W+2+$clog2(NCH); elaboration error otherwise.

Ports:
- CLK  in  1  mixer clock. Single clock domain; all sources are synchronous to it.
- RESET  in  1  asynchronous, active-high reset.
- CEN  in  1  sample strobe, one CLK cycle wide.
- CH_DIN  in  NCH*W  channel samples, signed; channel i at [i*W +: W].
- CH_EN  in  NCH  per-channel enable; 0 contributes zero.
- CH_LEVEL  in  2*NCH  per-channel gain code; channel i at [2i +: 2].
- CH_PAN  in  2*NCH  per-channel routing {L,R}; channel i at [2i +: 2]. Bit1 routes to left, bit0 to right.
- MUTE  in  1  forces outputs to zero; timing unchanged (driven from DIP_PAUSE).
- LEFT  out  OUT_W  mixed left sample, signed.
- RIGHT  out  OUT_W  mixed right sample, signed.
- SAMPLE  out  1  one-cycle pulse when LEFT/RIGHT update.
- PEAK  out  1  high while the current output pair contains a clipped side.
- BUSY  out  1  high while not in IDLE.
- OVERRUN  out  1  sticky: a CEN arrived while BUSY.

Behaviour:
- Reset (async):
  - State IDLE; accumulators and index cleared.
  - LEFT=0, RIGHT=0, SAMPLE=0, PEAK=0, BUSY=0, OVERRUN=0.
  - Reset mid-operation abandons the sample; no SAMPLE pulse is produced for it.
- Gain codes:
  - 0 = x0.5, arithmetic shift right 1; truncates toward -inf.
  - 1 = x1.
  - 2 = x2, shift left 1.
  - 3 = x4, shift left 2.
  - Each term is sign-extended to ACC_W before shifting, so a term cannot overflow the accumulator.
- State machine IDLE -> ACCUM -> OUTPUT -> IDLE:
  - IDLE: on the CLK edge with CEN=1, snapshot CH_DIN, CH_EN, CH_LEVEL and CH_PAN into internal registers, clear accL/accR, set idx=0, go to ACCUM. Later input changes do not affect this sample.
  - ACCUM: one channel per cycle. term = CH_EN[idx] ? gain(din[idx]) : 0. Add term to accL if pan[idx][1], to accR if pan[idx][0]. idx++. After idx=NCH-1, go to OUTPUT. Duration is exactly NCH cycles.
  - OUTPUT: saturate each accumulator to OUT_W. Values above 2^(OUT_W-1)-1 clamp to max; values below -2^(OUT_W-1) clamp to min. Register LEFT/RIGHT (0 if MUTE). PEAK = clipL|clipR, computed even when MUTE=1. SAMPLE=1 for this cycle. Return to IDLE.
- Latency:
  - CEN sampled high at edge t gives SAMPLE high during the cycle after edge t+NCH+1.
  - LEFT/RIGHT/PEAK are valid from that edge and held until the next OUTPUT.
- Strobe spacing:
  - Minimum CEN spacing is NCH+2 cycles.
  - CEN while BUSY=1 (ACCUM or OUTPUT) is ignored and sets OVERRUN. The in-flight sample completes normally.
  - CEN coincident with the OUTPUT cycle is also ignored.
- BUSY = (state != IDLE).
- Behaviour per gain code and pan is purely data-driven. A channel with pan=00 contributes nothing but still takes its cycle.

Test Plan:
- Reset, then CEN with NCH=4, ch0=1000, level=1, pan=11, others disabled -> SAMPLE exactly 5 cycles after the CEN edge; LEFT=RIGHT=1000; PEAK=0.
- Gain codes on ch0=-3:
  - level 0 -> -2 (asr).
  - level 2 -> -6.
  - level 3 -> -12.
- Pan, ch0=100 L-only and ch1=-50 R-only -> LEFT=100, RIGHT=-50.
- Clipping, all 4 channels at 32767 with level 3, pan=11 -> LEFT=RIGHT=32767 and PEAK=1. Then all at -32768 -> -32768 and PEAK=1. Next normal sample -> PEAK=0.
- Overrun: second CEN 2 cycles after the first -> only one SAMPLE, OVERRUN=1 and sticky until RESET. Output equals the first snapshot even if CH_DIN changes during ACCUM.
- MUTE=1 with a clipping input -> LEFT=RIGHT=0, SAMPLE pulses, PEAK=1.
- Assert RESET during ACCUM -> all outputs 0 immediately, no SAMPLE; the next CEN after release mixes correctly.
